// File: rtl/pipe_scroller.sv
// Pipe obstacle generator: scrolls five pipes left once per game tick,
// respawns them at the right edge with an LFSR-derived gap, and counts passes.
module pipe_scroller #(
  parameter int unsigned TICK_DIV  = 833333,
  parameter int unsigned Y_MAX     = 100,
  parameter logic [6:0]  LFSR_SEED = 7'h5A
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       collided,
  output logic [7:0] pipe_x1,
  output logic [7:0] pipe_x2,
  output logic [7:0] pipe_x3,
  output logic [7:0] pipe_x4,
  output logic [7:0] pipe_x5,
  output logic [6:0] pipe_y1,
  output logic [6:0] pipe_y2,
  output logic [6:0] pipe_y3,
  output logic [6:0] pipe_y4,
  output logic [6:0] pipe_y5,
  output logic [7:0] score,
  output logic       step,
  output logic       running
);

  localparam int          CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);
  localparam logic [6:0]  SEED = (LFSR_SEED == 7'd0) ? 7'h01 : LFSR_SEED;
  localparam logic [6:0]  YM   = 7'(Y_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic [7:0]    x_q [5];
  logic [7:0]    x_d [5];
  logic [6:0]    y_q [5];
  logic [6:0]    y_d [5];
  logic [7:0]    score_q, score_d;
  logic          step_q, step_d;
  logic          running_q, running_d;
  logic [6:0]    respawn_y;
  logic          pass_hit;

  // Out-of-range LFSR values fold down by 64 so every gap fits on screen.
  function automatic logic [6:0] fold_gap(input logic [6:0] v);
    return (v > YM) ? (v - 7'd64) : v;
  endfunction

  // Next-state: FSM, tick divider, LFSR and per-pipe scroll/respawn.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    x_d       = x_q;
    y_d       = y_q;
    score_d   = score_q;
    step_d    = 1'b0;
    pass_hit  = 1'b0;
    respawn_y = fold_gap(lfsr_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Collision beats a coincident terminal count.
        if (collided) begin
          state_d = S_HALT;
        end else if (cnt_q == TC) begin
          cnt_d  = '0;
          step_d = 1'b1;
          for (int i = 0; i < 5; i++) begin
            if (x_q[i] == 8'd0) begin
              x_d[i] = 8'd159;
              y_d[i] = respawn_y;
            end else begin
              x_d[i] = x_q[i] - 8'd1;
            end
            if (x_q[i] == 8'd4) begin
              pass_hit = 1'b1;
            end else begin
              pass_hit = pass_hit;
            end
          end
          if (pass_hit && (score_q != 8'd255)) begin
            score_d = score_q + 8'd1;
          end else begin
            score_d = score_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      x_q[0]    <= 8'd31;
      x_q[1]    <= 8'd63;
      x_q[2]    <= 8'd95;
      x_q[3]    <= 8'd127;
      x_q[4]    <= 8'd159;
      y_q[0]    <= 7'd40;
      y_q[1]    <= 7'd60;
      y_q[2]    <= 7'd20;
      y_q[3]    <= 7'd80;
      y_q[4]    <= 7'd50;
      score_q   <= 8'd0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      score_q   <= score_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign pipe_x1 = x_q[0];
  assign pipe_x2 = x_q[1];
  assign pipe_x3 = x_q[2];
  assign pipe_x4 = x_q[3];
  assign pipe_x5 = x_q[4];
  assign pipe_y1 = y_q[0];
  assign pipe_y2 = y_q[1];
  assign pipe_y3 = y_q[2];
  assign pipe_y4 = y_q[3];
  assign pipe_y5 = y_q[4];
  assign score   = score_q;
  assign step    = step_q;
  assign running = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with TICK_DIV=4; a small LFSR model
// supplies the expected respawn gaps.
module tb_pipe_scroller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       collided;
  logic [7:0] pipe_x1, pipe_x2, pipe_x3, pipe_x4, pipe_x5;
  logic [6:0] pipe_y1, pipe_y2, pipe_y3, pipe_y4, pipe_y5;
  logic [7:0] score;
  logic       step;
  logic       running;

  logic [7:0] px [5];
  logic [6:0] py [5];
  logic [6:0] lfsr_m;
  logic [6:0] lfsr_prev;
  int         checks;
  int         failures;

  pipe_scroller #(.TICK_DIV(4), .Y_MAX(100), .LFSR_SEED(7'h5A)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .collided(collided),
    .pipe_x1(pipe_x1), .pipe_x2(pipe_x2), .pipe_x3(pipe_x3),
    .pipe_x4(pipe_x4), .pipe_x5(pipe_x5),
    .pipe_y1(pipe_y1), .pipe_y2(pipe_y2), .pipe_y3(pipe_y3),
    .pipe_y4(pipe_y4), .pipe_y5(pipe_y5),
    .score(score), .step(step), .running(running)
  );

  assign px[0] = pipe_x1;
  assign px[1] = pipe_x2;
  assign px[2] = pipe_x3;
  assign px[3] = pipe_x4;
  assign px[4] = pipe_x5;
  assign py[0] = pipe_y1;
  assign py[1] = pipe_y2;
  assign py[2] = pipe_y3;
  assign py[3] = pipe_y4;
  assign py[4] = pipe_y5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic logic [6:0] gap_of(input logic [6:0] v);
    return (v > 7'd100) ? (v - 7'd64) : v;
  endfunction

  // LFSR model; lfsr_prev is the value the DUT used at the latest edge.
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= reset ? 7'h5A : lfsr_next(lfsr_m);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_x1"}, pipe_x1, 31);
    check_val({tag, "_x2"}, pipe_x2, 63);
    check_val({tag, "_x3"}, pipe_x3, 95);
    check_val({tag, "_x4"}, pipe_x4, 127);
    check_val({tag, "_x5"}, pipe_x5, 159);
    check_val({tag, "_y1"}, pipe_y1, 40);
    check_val({tag, "_y2"}, pipe_y2, 60);
    check_val({tag, "_y3"}, pipe_y3, 20);
    check_val({tag, "_y4"}, pipe_y4, 80);
    check_val({tag, "_y5"}, pipe_y5, 50);
    check_val({tag, "_score"}, score, 0);
    check_val({tag, "_step"}, step, 0);
    check_val({tag, "_running"}, running, 0);
  endtask

  // One scroll period: three quiet cycles, then the step pulse.
  task automatic run_step();
    int early;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (step) early++;
    end
    cyc();
    check_val("early_step", early, 0);
    check_val("step_pulse", step, 1);
    for (int p = 0; p < 5; p++) begin
      if (px[p] == 8'd159) begin
        check_val("respawn_y", py[p], gap_of(lfsr_prev));
        check_val("y_range", (py[p] <= 7'd100) ? 1 : 0, 1);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_val("running_after_start", running, 1);
  endtask

  initial begin
    int pulses;
    int guard;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    collided = 1'b0;

    // Reset and idle
    cyc();
    cyc();
    reset = 1'b0;
    check_reset_values("rst");
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      collided = (i == 50);
      cyc();
      if (step || running) pulses++;
    end
    collided = 1'b0;
    check_val("idle_quiet", pulses, 0);
    check_reset_values("idle");

    // Scroll and score
    pulse_start();
    for (int k = 1; k <= 188; k++) begin
      run_step();
      if (k == 1)   check_val("s1_x1", pipe_x1, 30);
      if (k == 27)  check_val("s27_score", score, 0);
      if (k == 28)  check_val("s28_score", score, 1);
      if (k == 31)  check_val("s31_x1", pipe_x1, 0);
      if (k == 32) begin
        check_val("s32_x1", pipe_x1, 159);
        check_val("s32_y1", pipe_y1, gap_of(lfsr_prev));
        check_val("s32_x2", pipe_x2, 31);
      end
      if (k == 188) begin
        check_val("s188_score", score, 6);
        check_val("s188_x1", pipe_x1, 3);
        check_val("s188_x2", pipe_x2, 35);
      end
    end

    // Collision on a terminal-count edge
    for (int i = 0; i < 3; i++) cyc();
    collided = 1'b1;
    cyc();
    collided = 1'b0;
    check_val("halt_running", running, 0);
    check_val("halt_step", step, 0);
    check_val("halt_x1", pipe_x1, 3);
    check_val("halt_x2", pipe_x2, 35);
    check_val("halt_score", score, 6);
    start = 1'b1;
    cyc();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step || running) pulses++;
    end
    check_val("halt_quiet", pulses, 0);
    check_val("halt_x1_late", pipe_x1, 3);

    // Reset wins over start
    reset = 1'b1;
    start = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b0;
    check_val("rst_start_running", running, 0);

    // Reset mid-run at step 50
    pulse_start();
    for (int k = 1; k <= 49; k++) run_step();
    check_val("s49_x1", pipe_x1, 142);
    for (int i = 0; i < 3; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_values("midrst");

    // Time the start so step 32 respawns pipe 1 from LFSR 7'h7F
    guard = 0;
    while ((lfsr_next(lfsr_m) != 7'h7F) && (guard < 200)) begin
      cyc();
      guard++;
    end
    check_val("lfsr_align_timeout", (guard < 200) ? 1 : 0, 1);
    pulse_start();
    for (int k = 1; k <= 32; k++) run_step();
    check_val("lfsr7f_x1", pipe_x1, 159);
    check_val("lfsr7f_y1", pipe_y1, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
